alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_iter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: iterative ALU. Single-cycle ops (add/sub/logic/shift/compare)
// finish one cycle after accept; MULU (and DIVU/REMU when the divider is
// built) run WIDTH iterations on a shared 2*WIDTH shift register.
//
// Build option: define ALU_ITER_DIV_EN to include the restoring divider.
// Without it, ops 12/13 behave like undefined ops.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             accept op/a/b/carry_in when the FSM is idle
//   op[4:0]           operation code
//   a, b [WIDTH]      operands, sampled on accept
//   carry_in          carry/borrow for ADDC/SUBC
//   busy              high while an iterative op runs
//   done              one-cycle pulse; result/flags held until next done
//   result [WIDTH]    result
//   carry_out, zero_out, neg_out, over_out   flags
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             over_out
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,
                         OP_SUBC = 5'd3,  OP_AND  = 5'd4,  OP_OR   = 5'd5,
                         OP_XOR  = 5'd6,  OP_COMP = 5'd7,  OP_SHL  = 5'd8,
                         OP_SHR  = 5'd9,  OP_ASR  = 5'd10, OP_MULU = 5'd11;
`ifdef ALU_ITER_DIV_EN
  localparam logic [4:0] OP_DIVU = 5'd12, OP_REMU = 5'd13;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      cnt;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   m_q;         // multiplicand (MULU) or divisor (DIVU/REMU)
  logic [2*WIDTH-1:0] p_q, p_nxt;  // {hi, lo} product / {rem, quotient}

  logic accept, iter_op;

  assign accept = start && (state == IDLE);

`ifdef ALU_ITER_DIV_EN
  assign iter_op = (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
`else
  assign iter_op = (op == OP_MULU);
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = iter_op ? RUN : DONE;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] s_res, s_src;   // s_src drives zero/neg (differs for COMP)
  logic             s_c, s_v;
  logic [SW-1:0]    sh;

  assign sh = b[SW-1:0];

  always_comb begin
    ext   = '0;
    s_res = '0;
    s_src = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) && carry_in};
        s_res = ext[WIDTH-1:0];
        s_src = s_res;
        s_c   = ext[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBC, OP_COMP: begin
        // bit WIDTH of the extended difference is the borrow
        ext   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SUBC) && carry_in};
        s_src = ext[WIDTH-1:0];
        s_res = (op == OP_COMP) ? a : ext[WIDTH-1:0];
        s_c   = ext[WIDTH];
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin s_res = a & b; s_src = s_res; end
      OP_OR:  begin s_res = a | b; s_src = s_res; end
      OP_XOR: begin s_res = a ^ b; s_src = s_res; end
      // Shifts carry one guard bit so the last bit out lands in it;
      // a zero count leaves the guard at 0.
      OP_SHL: begin
        ext   = {1'b0, a} << sh;
        s_res = ext[WIDTH-1:0];
        s_src = s_res;
        s_c   = ext[WIDTH];
      end
      OP_SHR: begin
        ext   = {a, 1'b0} >> sh;
        s_res = ext[WIDTH:1];
        s_src = s_res;
        s_c   = ext[0];
      end
      OP_ASR: begin
        ext   = $signed({a, 1'b0}) >>> sh;
        s_res = ext[WIDTH:1];
        s_src = s_res;
        s_c   = ext[0];
      end
      default: ;  // undefined ops: everything 0, zero_out follows from s_src
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic [WIDTH:0]   hi_sum;
  logic [WIDTH-1:0] i_res;
  logic             i_c, i_v;
`ifdef ALU_ITER_DIV_EN
  logic [2*WIDTH:0] shl_p;
  logic [WIDTH:0]   top, top_d;
`endif

  always_comb begin
    hi_sum = '0;
    p_nxt  = p_q;
    i_res  = '0;
    i_c    = 1'b0;
    i_v    = 1'b0;
`ifdef ALU_ITER_DIV_EN
    shl_p  = '0;
    top    = '0;
    top_d  = '0;
`endif
    if (op_q == OP_MULU) begin
      // shift-add: conditionally add multiplicand to the high half, shift right
      hi_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
      p_nxt  = {hi_sum, p_q[WIDTH-1:1]};
      i_res  = p_nxt[WIDTH-1:0];
      i_c    = |p_nxt[2*WIDTH-1:WIDTH];
    end
`ifdef ALU_ITER_DIV_EN
    else begin
      // restoring division; a zero divisor naturally yields quotient all-ones
      // and remainder equal to the dividend
      shl_p = {p_q, 1'b0};
      top   = shl_p[2*WIDTH:WIDTH];
      if (top >= {1'b0, m_q}) begin
        top_d = top - {1'b0, m_q};
        p_nxt = {top_d[WIDTH-1:0], shl_p[WIDTH-1:1], 1'b1};
      end else begin
        p_nxt = {top[WIDTH-1:0], shl_p[WIDTH-1:0]};
      end
      i_res = (op_q == OP_REMU) ? p_nxt[2*WIDTH-1:WIDTH] : p_nxt[WIDTH-1:0];
      i_v   = (m_q == '0);
    end
`endif
  end

  // ---------------- registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      op_q      <= '0;
      m_q       <= '0;
      p_q       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
      neg_out   <= 1'b0;
      over_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op;
          cnt  <= '0;
          if (iter_op) begin
            m_q <= (op == OP_MULU) ? a : b;
            p_q <= (op == OP_MULU) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
          end else begin
            result    <= s_res;
            carry_out <= s_c;
            zero_out  <= (s_src == '0);
            neg_out   <= s_src[WIDTH-1];
            over_out  <= s_v;
          end
        end
        RUN: begin
          p_q <= p_nxt;
          cnt <= cnt + SW'(1);
          if (cnt == LAST) begin
            result    <= i_res;
            carry_out <= i_c;
            zero_out  <= (i_res == '0);
            neg_out   <= i_res[WIDTH-1];
            over_out  <= i_v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // WIDTH=32 instance signals
  logic        start32, cin32, busy32, done32, c32, z32, n32, v32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, res32;
  // WIDTH=8 instance signals
  logic        start8, cin8, busy8, done8, c8, z8, n8, v8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, res8;

  alu_iter #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .carry_in(cin32), .busy(busy32), .done(done32), .result(res32),
    .carry_out(c32), .zero_out(z32), .neg_out(n32), .over_out(v32));

  alu_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .carry_in(cin8), .busy(busy8), .done(done8), .result(res8),
    .carry_out(c8), .zero_out(z8), .neg_out(n8), .over_out(v8));

  // view of whichever instance the current test targets
  bit          sel8;
  logic [63:0] cur_res;
  logic        cur_busy, cur_done;
  logic [3:0]  cur_flags;  // {carry, zero, neg, over}
  assign cur_res   = sel8 ? {56'b0, res8} : {32'b0, res32};
  assign cur_busy  = sel8 ? busy8 : busy32;
  assign cur_done  = sel8 ? done8 : done32;
  assign cur_flags = sel8 ? {c8, z8, n8, v8} : {c32, z32, n32, v32};

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          w;
    logic [63:0] res;
    logic        c, z, n, v;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int w, input logic [4:0] op,
                                 input logic [63:0] ai, input logic [63:0] bi,
                                 input logic cin);
    exp_t        e;
    logic [63:0] mask, a, b, r, d, p;
    longint      sa;
    logic        ci;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    a = ai & mask;
    b = bi & mask;
    sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
    ci = (op == 5'd1 || op == 5'd3) ? cin : 1'b0;
    sh = int'(b[5:0]) & (w - 1);
    e.w = w; e.lat = 1; e.c = 1'b0; e.v = 1'b0; r = '0;
    case (op)
      5'd0, 5'd1: begin
        d = a + b + {63'b0, ci};
        r = d & mask;
        e.c = d[w];
        e.v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      5'd2, 5'd3, 5'd7: begin
        d = a - b - {63'b0, ci};
        r = d & mask;
        e.c = (a < b + {63'b0, ci});
        e.v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      5'd4: r = a & b;
      5'd5: r = a | b;
      5'd6: r = a ^ b;
      5'd8: begin
        r = (a << sh) & mask;
        e.c = (sh != 0) ? a[w-sh] : 1'b0;
      end
      5'd9: begin
        r = a >> sh;
        e.c = (sh != 0) ? a[sh-1] : 1'b0;
      end
      5'd10: begin
        r = 64'(sa >>> sh) & mask;
        e.c = (sh != 0) ? a[sh-1] : 1'b0;
      end
      5'd11: begin
        p = a * b;
        r = p & mask;
        e.c = ((p >> w) != 64'd0);
        e.lat = w + 1;
      end
`ifdef ALU_ITER_DIV_EN
      5'd12: begin
        r = (b == 0) ? mask : a / b;
        e.v = (b == 0);
        e.lat = w + 1;
      end
      5'd13: begin
        r = (b == 0) ? a : a % b;
        e.v = (b == 0);
        e.lat = w + 1;
      end
`endif
      default: r = '0;
    endcase
    e.res = (op == 5'd7) ? a : r;
    e.z = (r == 64'd0);
    e.n = r[w-1];
    return e;
  endfunction

  task automatic drive(input int w, input logic st, input logic [4:0] o,
                       input logic [63:0] x, input logic [63:0] y, input logic ci);
    if (w == 8) begin
      start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0]; cin8 = ci;
    end else begin
      start32 = st; op32 = o; a32 = x[31:0]; b32 = y[31:0]; cin32 = ci;
    end
  endtask

  // Issue one op, push its expectation, wait for done, pop and compare.
  task automatic do_op(input int w, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic cin, input string name,
                       input bit mid_start);
    exp_t e;
    int   lat, busy_cnt;
    sel8 = (w == 8);
    sb.push_back(model(w, op, a, b, cin));
    @(negedge clock);
    drive(w, 1'b1, op, a, b, cin);
    @(posedge clock); #1;
    drive(w, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    lat = 1;
    busy_cnt = 0;
    while (!cur_done && lat < 200) begin
      if (cur_busy) busy_cnt++;
      if (mid_start && lat == 10) drive(w, 1'b1, 5'd0, 64'd2, 64'd3, 1'b0);
      @(posedge clock); #1;
      drive(w, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (cur_done !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, cur_done, lat);
      return;
    end
    checks++;
    if (lat !== e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    end
    checks++;
    if (busy_cnt !== e.lat - 1) begin
      fails++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, busy_cnt, e.lat - 1);
    end
    checks++;
    if (cur_res !== e.res || cur_flags !== {e.c, e.z, e.n, e.v}) begin
      fails++;
      $display("FAIL %s result: got %h cznv=%b required %h cznv=%b",
               name, cur_res, cur_flags, e.res, {e.c, e.z, e.n, e.v});
    end
    // done is a pulse, result is held
    @(posedge clock); #1;
    checks++;
    if (cur_done !== 1'b0 || cur_res !== e.res) begin
      fails++;
      $display("FAIL %s hold: done=%b res=%h required done=0 res=%h", name, cur_done, cur_res, e.res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    // start during reset must be ignored
    drive(32, 1'b1, 5'd0, 64'd2, 64'd3, 1'b0);
    drive(8,  1'b1, 5'd0, 64'd2, 64'd3, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy32, done32, res32, c32, z32, n32, v32} !== 38'd0 ||
        {busy8, done8, res8, c8, z8, n8, v8} !== 14'd0) begin
      fails++;
      $display("FAIL reset_state: b32=%b d32=%b r32=%h b8=%b d8=%b r8=%h required all 0",
               busy32, done32, res32, busy8, done8, res8);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    drive(8,  1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    @(posedge clock); #1;
    checks++;
    if (done32 !== 1'b0 || res32 !== 32'd0 || done8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: done32=%b res32=%h done8=%b required 0", done32, res32, done8);
    end
    // first accept right after reset deasserts
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    do_op(32, 5'd0, 64'd2, 64'd3, 1'b0, "first_accept_add", 1'b0);
  endtask

  task automatic test_arith();
    do_op(32, 5'd0, 64'h7FFFFFFF, 64'h1, 1'b0, "add_ovf", 1'b0);
    do_op(32, 5'd1, 64'hFFFFFFFF, 64'h0, 1'b1, "addc_wrap", 1'b0);
    do_op(32, 5'd1, 64'h12345678, 64'h11111111, 1'b0, "addc_nocin", 1'b0);
    do_op(32, 5'd2, 64'h0, 64'h1, 1'b0, "sub_borrow", 1'b0);
    do_op(32, 5'd3, 64'h5, 64'h3, 1'b1, "subc", 1'b0);
    do_op(32, 5'd2, 64'h80000000, 64'h1, 1'b0, "sub_ovf", 1'b0);
    do_op(32, 5'd7, 64'h0, 64'h1, 1'b0, "comp", 1'b0);
    do_op(32, 5'd7, 64'h9, 64'h9, 1'b0, "comp_eq", 1'b0);
  endtask

  task automatic test_logic();
    do_op(32, 5'd4, 64'hF0F0F0F0, 64'hFF00FF00, 1'b0, "and", 1'b0);
    do_op(32, 5'd5, 64'h0F0F0000, 64'h8000000F, 1'b0, "or", 1'b0);
    do_op(32, 5'd6, 64'hA5A5A5A5, 64'hA5A5A5A5, 1'b0, "xor_zero", 1'b0);
    do_op(32, 5'd14, 64'h12, 64'h34, 1'b1, "undef_14", 1'b0);
    do_op(32, 5'd31, 64'hFFFFFFFF, 64'h1, 1'b0, "undef_31", 1'b0);
  endtask

  task automatic test_shift();
    do_op(32, 5'd10, 64'h80000000, 64'd4, 1'b0, "asr", 1'b0);
    do_op(32, 5'd8, 64'h80000001, 64'd1, 1'b0, "shl_carry", 1'b0);
    do_op(32, 5'd8, 64'h12345678, 64'd0, 1'b0, "shl_zero_cnt", 1'b0);
    do_op(32, 5'd9, 64'h0000000F, 64'd4, 1'b0, "shr_carry", 1'b0);
    do_op(32, 5'd10, 64'h8000000F, 64'h24, 1'b0, "asr_cnt_masked", 1'b0);
    do_op(32, 5'd9, 64'h80000000, 64'd31, 1'b0, "shr_max", 1'b0);
  endtask

  task automatic test_mul();
    do_op(32, 5'd11, 64'h00010000, 64'h00010001, 1'b0, "mulu_mid_start", 1'b1);
    do_op(32, 5'd11, 64'd1234, 64'd5678, 1'b0, "mulu_small", 1'b0);
    do_op(32, 5'd11, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, "mulu_max", 1'b0);
    do_op(32, 5'd11, 64'h0, 64'hDEADBEEF, 1'b0, "mulu_zero", 1'b0);
  endtask

  task automatic test_div();
    do_op(32, 5'd12, 64'd100, 64'd7, 1'b0, "divu", 1'b0);
    do_op(32, 5'd13, 64'd100, 64'd7, 1'b0, "remu", 1'b0);
    do_op(32, 5'd12, 64'd5, 64'd0, 1'b0, "divu_by0", 1'b0);
    do_op(32, 5'd13, 64'd5, 64'd0, 1'b0, "remu_by0", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    sel8 = 1'b0;
    @(negedge clock);
    drive(32, 1'b1, 5'd11, 64'hFFFF, 64'hFFFF, 1'b0);
    @(posedge clock); #1;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({busy32, done32, res32, c32, z32, n32, v32} !== 38'd0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b res=%h flags=%b required all 0",
               busy32, done32, res32, {c32, z32, n32, v32});
    end
    @(negedge clock);
    reset = 1'b0;
    do_op(32, 5'd0, 64'd2, 64'd3, 1'b0, "add_after_reset", 1'b0);
  endtask

  task automatic test_width8();
    do_op(8, 5'd0, 64'h7F, 64'h1, 1'b0, "w8_add_ovf", 1'b0);
    do_op(8, 5'd0, 64'd2, 64'd3, 1'b0, "w8_add", 1'b0);
    do_op(8, 5'd11, 64'h10, 64'h11, 1'b0, "w8_mulu_hi", 1'b0);
    do_op(8, 5'd11, 64'd13, 64'd11, 1'b0, "w8_mulu", 1'b0);
    do_op(8, 5'd12, 64'd200, 64'd9, 1'b0, "w8_divu", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [63:0] x, y;
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 15));
      x = {32'b0, $urandom()};
      y = {32'b0, $urandom()};
      if (i % 5 == 0) y = 64'd0;
      do_op((i % 3 == 0) ? 8 : 32, op, x, y, 1'($urandom_range(0, 1)), "random", 1'b0);
    end
  endtask

  initial begin
    sel8 = 1'b0;
    reset = 1'b1;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    drive(8,  1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_div();
    test_reset_mid_run();
    test_width8();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
